// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - datapath of the sequential 8x8 multiplier
//
// Each cycle one 4x4 nibble product is formed from the captured operands. It is
// shifted by 0/4/8 bits and added into a 16-bit accumulator, all under control
// of the multiplier FSM.
//
// Ports:
//   clk            system clock, rising edge
//   reset_a        synchronous active-high reset, highest priority
//   start          begin a new multiply: capture operands, clear step count
//   dataa, datab   8-bit multiplicand / multiplier (sampled only on start)
//   input_sel      bit0 = dataa nibble, bit1 = datab nibble (0 low, 1 high)
//   shift_sel      00 <<0, 01 <<4, 10 <<8, 11 treated as <<0
//   clk_ena        accumulator enable
//   sclr_n         accumulator clear (active-low), only while clk_ena=1
//   count          free-running 2-bit step count returned to the FSM
//   product8x8_out accumulator contents
module mult_datapath (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  input  logic [1:0]  input_sel,
  input  logic [1:0]  shift_sel,
  input  logic        clk_ena,
  input  logic        sclr_n,
  output logic [1:0]  count,
  output logic [15:0] product8x8_out
);

  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [15:0] term;
  logic [15:0] acc;

  // Partial product always comes from the captured operands, so dataa/datab
  // are free to change once the start cycle has passed.
  always_comb begin
    nib_a = input_sel[0] ? opa[7:4] : opa[3:0];
    nib_b = input_sel[1] ? opb[7:4] : opb[3:0];
    pp    = {4'b0000, nib_a} * {4'b0000, nib_b};
    case (shift_sel)
      2'b01:   term = {4'b0000, pp, 4'b0000};
      2'b10:   term = {pp, 8'b0000_0000};
      default: term = {8'b0000_0000, pp};   // 00 and reserved 11
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      opa <= 8'h00;
      opb <= 8'h00;
    end else if (start) begin
      opa <= dataa;
      opb <= datab;
    end
  end

  // Step counter runs every cycle; only start (or reset) re-aligns it.
  always_ff @(posedge clk) begin
    if (reset_a)
      count <= 2'd0;
    else if (start)
      count <= 2'd0;
    else
      count <= count + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset_a)
      acc <= 16'h0000;
    else if (clk_ena) begin
      if (!sclr_n)
        acc <= 16'h0000;
      else
        acc <= acc + term;
    end
  end

  assign product8x8_out = acc;

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - self-checking bench for mult_datapath
module tb_mult_datapath;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [1:0]  input_sel;
  logic [1:0]  shift_sel;
  logic        clk_ena;
  logic        sclr_n;
  logic [1:0]  count;
  logic [15:0] product8x8_out;

  int checks = 0;
  int errors = 0;

  mult_datapath dut (
    .clk            (clk),
    .reset_a        (reset_a),
    .start          (start),
    .dataa          (dataa),
    .datab          (datab),
    .input_sel      (input_sel),
    .shift_sel      (shift_sel),
    .clk_ena        (clk_ena),
    .sclr_n         (sclr_n),
    .count          (count),
    .product8x8_out (product8x8_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: operand latch, step counter, accumulator as arithmetic.
  int unsigned m_opa, m_opb, m_count, m_acc;
  bit          model_valid = 0;

  function automatic int unsigned shifted_term(int unsigned a, int unsigned b,
                                               logic [1:0] isel, logic [1:0] ssel);
    int unsigned na, nb, mult;
    na   = isel[0] ? (a / 16) : (a % 16);
    nb   = isel[1] ? (b / 16) : (b % 16);
    mult = (ssel == 2'd1) ? 16 : (ssel == 2'd2) ? 256 : 1;
    return na * nb * mult;
  endfunction

  always @(posedge clk) begin
    if (reset_a) begin
      m_opa = 0; m_opb = 0; m_count = 0; m_acc = 0;
      model_valid = 1;
    end else begin
      if (clk_ena)
        m_acc = sclr_n ? (m_acc + shifted_term(m_opa, m_opb, input_sel, shift_sel)) % 65536 : 0;
      if (start) begin
        m_opa = dataa; m_opb = datab; m_count = 0;
      end else begin
        m_count = (m_count + 1) % 4;
      end
    end
  end

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_count", 32'(count), m_count);
      chk("model_product", 32'(product8x8_out), m_acc);
    end
  end

  task automatic apply(input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic en, input logic sc,
                       input logic [1:0] isel, input logic [1:0] ssel);
    @(negedge clk);
    start = st; dataa = a; datab = b; clk_ena = en; sclr_n = sc;
    input_sel = isel; shift_sel = ssel;
  endtask

  // FSM-accurate multiply; operands are scrambled after the start cycle.
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input int unsigned exp,
                         input string name);
    apply(1, a, b, 1, 0, 2'b00, 2'b00);
    apply(0, 8'($urandom), 8'($urandom), 1, 1, 2'b00, 2'b00);
    apply(0, 8'($urandom), 8'($urandom), 1, 1, 2'b01, 2'b01);
    apply(0, 8'($urandom), 8'($urandom), 1, 1, 2'b10, 2'b01);
    apply(0, 8'($urandom), 8'($urandom), 1, 1, 2'b11, 2'b10);
    apply(0, 8'($urandom), 8'($urandom), 0, 1, 2'b00, 2'b00);
    chk(name, 32'(product8x8_out), exp);
    chk({name, "_count"}, 32'(count), 0);
  endtask

  initial begin
    int unsigned ra, rb;
    reset_a = 1; start = 1; dataa = 8'h5A; datab = 8'hC3;
    clk_ena = 1; sclr_n = 1; input_sel = 2'b11; shift_sel = 2'b10;

    // Reset wins over start with clk_ena=1
    apply(1, 8'hA7, 8'h3C, 1, 1, 2'b11, 2'b01);
    apply(1, 8'h11, 8'hEE, 1, 1, 2'b01, 2'b10);
    @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_product", 32'(product8x8_out), 0);
    reset_a = 0;

    // Nominal multiply with per-step literal values
    apply(1, 8'hC8, 8'h7D, 1, 0, 2'b00, 2'b00);
    apply(0, 8'h00, 8'h00, 1, 1, 2'b00, 2'b00);
    chk("nom_c0_acc", 32'(product8x8_out), 16'h0000);
    chk("nom_c0_count", 32'(count), 0);
    apply(0, 8'hFF, 8'hFF, 1, 1, 2'b01, 2'b01);
    chk("nom_c1_acc", 32'(product8x8_out), 16'h0068);
    chk("nom_c1_count", 32'(count), 1);
    apply(0, 8'h12, 8'h34, 1, 1, 2'b10, 2'b01);
    chk("nom_c2_acc", 32'(product8x8_out), 16'h0A28);
    chk("nom_c2_count", 32'(count), 2);
    apply(0, 8'h99, 8'h01, 1, 1, 2'b11, 2'b10);
    chk("nom_c3_acc", 32'(product8x8_out), 16'h0DA8);
    chk("nom_c3_count", 32'(count), 3);
    apply(0, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    chk("nom_c4_acc", 32'(product8x8_out), 16'h61A8);
    chk("nom_c4_count", 32'(count), 0);

    // Corner operands
    do_mult(8'hFF, 8'hFF, 16'hFE01, "ff_x_ff");
    do_mult(8'h00, 8'hA5, 16'h0000, "00_x_a5");
    do_mult(8'h01, 8'h80, 16'h0080, "01_x_80");

    // Enable gating: sclr_n=0 and nonzero term ignored while clk_ena=0
    do_mult(8'hC8, 8'h7D, 16'h61A8, "gate_setup");
    for (int i = 0; i < 3; i++) begin
      apply(0, 8'hFF, 8'hFF, 0, 0, 2'b11, 2'b10);
      chk("gate_hold", 32'(product8x8_out), 16'h61A8);
    end
    @(negedge clk);
    chk("gate_hold_end", 32'(product8x8_out), 16'h61A8);

    // Counter wrap and restart
    apply(1, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    apply(0, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_count", 32'(count), i % 4);
      apply(0, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    end
    apply(1, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    apply(0, 8'h00, 8'h00, 0, 1, 2'b00, 2'b00);
    chk("restart_count", 32'(count), 0);

    // Back-to-back, next start one cycle after done
    do_mult(8'h12, 8'h34, 16'h03A8, "b2b_first");
    do_mult(8'h56, 8'h78, 16'h2850, "b2b_second");

    // Reset mid-multiply abandons it
    apply(1, 8'hFF, 8'hFF, 1, 0, 2'b00, 2'b00);
    apply(0, 8'h00, 8'h00, 1, 1, 2'b00, 2'b00);
    apply(0, 8'h00, 8'h00, 1, 1, 2'b01, 2'b01);
    reset_a = 1;
    apply(0, 8'h00, 8'h00, 1, 1, 2'b10, 2'b01);
    reset_a = 0;
    chk("midreset_product", 32'(product8x8_out), 0);
    chk("midreset_count", 32'(count), 0);

    // Random legal multiplies against plain product
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      do_mult(8'(ra), 8'(rb), ra * rb, "rand_mult");
    end

    // Unconstrained random controls, checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      reset_a   = ($urandom_range(0, 49) == 0);
      start     = ($urandom_range(0, 7) == 0);
      dataa     = 8'($urandom);
      datab     = 8'($urandom);
      clk_ena   = 1'($urandom);
      sclr_n    = ($urandom_range(0, 5) != 0);
      input_sel = 2'($urandom);
      shift_sel = 2'($urandom);
    end
    @(negedge clk);
    reset_a = 0; start = 0; clk_ena = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
